ibex_mult_pext_ctrl: RTL and testbench



---
 rtl/ibex_pkg_pext.sv | 27 ++
 rtl/ibex_mult_pext_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ibex_mult_pext_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg_pext.sv
// Shared types for the P-extension multiplier sequencing logic.
// Phase encodings, controller states and cycle-count codes.
package ibex_pkg_pext;

    typedef enum logic [1:0] {
        PHASE_LO    = 2'b00,
        PHASE_HI    = 2'b01,
        PHASE_ACCUM = 2'b10
    } mult_pext_phase_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MULT1 = 2'b01,
        ACCUM = 2'b10,
        HOLD  = 2'b11
    } mult_pext_ctrl_state_e;

    localparam logic [1:0] CYC_CNT_1 = 2'b00;
    localparam logic [1:0] CYC_CNT_2 = 2'b01;
    localparam logic [1:0] CYC_CNT_3 = 2'b11;

    // The unused code 10 behaves as a 2-cycle op.
    function automatic logic [1:0] norm_cycle_count(logic [1:0] cnt);
        return (cnt == 2'b10) ? CYC_CNT_2 : cnt;
    endfunction

endpackage

// File: rtl/ibex_mult_pext_ctrl.sv
// Multi-cycle sequencer for the P-extension multiplier in EX.
// Steps partial-product phases, optional accumulate and sticky OV.
module ibex_mult_pext_ctrl
    import ibex_pkg_pext::*;
#(
    parameter int unsigned ImdWidth = 34,
    parameter bit          OvSticky = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       mult_en_i,
    input  logic       kill_i,
    input  logic [1:0] cycle_count_i,
    input  logic       accum_i,
    input  logic       accum_sub_i,
    input  logic       ready_id_i,
    input  logic       ov_i,
    output logic [1:0] phase_o,
    output logic       imd_we_o,
    output logic       alu_accum_o,
    output logic       alu_sub_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       ov_o
);

    // The intermediate register lives in the datapath; only its enable is here.
    if (ImdWidth < 2) begin : g_imd_narrow
    end

    mult_pext_ctrl_state_e state_q, state_d;
    mult_pext_phase_e      phase;

    logic [1:0] cnt_q, cnt_d;
    logic       acc_q, acc_d;
    logic       sub_q, sub_d;
    logic       ov_q, ov_d;

    logic       abort;
    logic       is3;
    logic       ov_merge;
    logic [1:0] cnt_in;

    assign abort    = kill_i | ~mult_en_i;
    assign is3      = (cnt_q == CYC_CNT_3);
    assign ov_merge = OvSticky ? (ov_q | ov_i) : ov_i;
    assign cnt_in   = norm_cycle_count(cycle_count_i);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sub_d       = sub_q;
        ov_d        = ov_q;
        phase       = PHASE_LO;
        imd_we_o    = 1'b0;
        alu_accum_o = 1'b0;
        alu_sub_o   = 1'b0;
        valid_o     = 1'b0;
        ov_o        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mult_en_i && !kill_i) begin
                    if (cnt_in == CYC_CNT_1) begin
                        valid_o = 1'b1;
                        ov_o    = ov_i;
                    end else begin
                        imd_we_o = 1'b1;
                        cnt_d    = cnt_in;
                        acc_d    = accum_i;
                        sub_d    = accum_sub_i;
                        ov_d     = ov_i;
                        state_d  = MULT1;
                    end
                end
            end

            MULT1: begin
                phase = PHASE_HI;
                if (abort) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end else if (is3) begin
                    imd_we_o = 1'b1;
                    ov_d     = ov_merge;
                    state_d  = ACCUM;
                end else begin
                    valid_o = 1'b1;
                    ov_o    = ov_merge;
                    if (ready_id_i) begin
                        ov_d    = 1'b0;
                        state_d = IDLE;
                    end else begin
                        ov_d    = ov_merge;
                        state_d = HOLD;
                    end
                end
            end

            ACCUM: begin
                phase       = PHASE_ACCUM;
                alu_accum_o = acc_q;
                alu_sub_o   = sub_q;
                if (abort) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    valid_o = 1'b1;
                    ov_o    = ov_merge;
                    if (ready_id_i) begin
                        ov_d    = 1'b0;
                        state_d = IDLE;
                    end else begin
                        ov_d    = ov_merge;
                        state_d = HOLD;
                    end
                end
            end

            HOLD: begin
                // Present the phase that produced the held result.
                phase       = is3 ? PHASE_ACCUM : PHASE_HI;
                alu_accum_o = is3 & acc_q;
                alu_sub_o   = is3 & sub_q;
                if (abort) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    valid_o = 1'b1;
                    ov_o    = ov_q;
                    if (ready_id_i) begin
                        ov_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= CYC_CNT_1;
            acc_q   <= 1'b0;
            sub_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sub_q   <= sub_d;
            ov_q    <= ov_d;
        end
    end

    assign phase_o = phase;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_mult_pext_ctrl.sv
// Bench for ibex_mult_pext_ctrl: sticky and non-sticky OV instances
// checked each cycle against a transaction-level reference model.
module tb_ibex_mult_pext_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, kill, acc, sub, rdy, ov;
    logic [1:0] cc;

    logic [1:0] ph_s, ph_n;
    logic       we_s, we_n, aa_s, aa_n, as_s, as_n;
    logic       vl_s, vl_n, bz_s, bz_n, ov_s, ov_n;

    int checks   = 0;
    int failures = 0;

    ibex_mult_pext_ctrl #(.ImdWidth(34), .OvSticky(1'b1)) u_sticky (
        .clk_i(clk), .rst_ni(rst_n), .mult_en_i(en), .kill_i(kill),
        .cycle_count_i(cc), .accum_i(acc), .accum_sub_i(sub),
        .ready_id_i(rdy), .ov_i(ov), .phase_o(ph_s), .imd_we_o(we_s),
        .alu_accum_o(aa_s), .alu_sub_o(as_s), .valid_o(vl_s),
        .busy_o(bz_s), .ov_o(ov_s)
    );

    ibex_mult_pext_ctrl #(.ImdWidth(34), .OvSticky(1'b0)) u_plain (
        .clk_i(clk), .rst_ni(rst_n), .mult_en_i(en), .kill_i(kill),
        .cycle_count_i(cc), .accum_i(acc), .accum_sub_i(sub),
        .ready_id_i(rdy), .ov_i(ov), .phase_o(ph_n), .imd_we_o(we_n),
        .alu_accum_o(aa_n), .alu_sub_o(as_n), .valid_o(vl_n),
        .busy_o(bz_n), .ov_o(ov_n)
    );

    always #5 clk = ~clk;

    // Reference model: an in-flight op described by its length and progress.
    bit m_act, m_held, m_acc, m_sub;
    int m_step, m_len;
    bit m_ov[2];

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit merge(int k, bit a, bit b);
        return (k == 0) ? (a | b) : b;
    endfunction

    function automatic logic [7:0] dut_out(int k);
        if (k == 0)
            return {ph_s, we_s, aa_s, as_s, vl_s, bz_s, ov_s};
        return {ph_n, we_n, aa_n, as_n, vl_n, bz_n, ov_n};
    endfunction

    task automatic model_clear();
        m_act  = 0;
        m_held = 0;
        m_step = 0;
        m_len  = 0;
        m_acc  = 0;
        m_sub  = 0;
        m_ov   = '{0, 0};
    endtask

    // Called 1 time unit after a rising edge; returns at the same offset.
    task automatic cyc(input string tag, input bit e, input bit kl,
                       input logic [1:0] c, input bit a, input bit s,
                       input bit r, input bit o);
        logic [1:0] eph;
        bit         ewe, eaa, eas, evl, ebz;
        bit         eov[2];
        bit         n_act, n_held, n_acc, n_sub;
        int         n_step, n_len;
        bit         n_ov[2];
        en = e; kill = kl; cc = c; acc = a; sub = s; rdy = r; ov = o;
        #3;
        eph = 2'd0; ewe = 0; eaa = 0; eas = 0; evl = 0; ebz = 0;
        eov = '{0, 0};
        n_act = m_act; n_held = m_held; n_step = m_step; n_len = m_len;
        n_acc = m_acc; n_sub = m_sub; n_ov = m_ov;
        if (!m_act) begin
            if (e && !kl) begin
                if (c == 2'b00) begin
                    evl = 1;
                    eov = '{o, o};
                end else begin
                    ewe    = 1;
                    n_act  = 1;
                    n_held = 0;
                    n_step = 1;
                    n_len  = (c == 2'b11) ? 3 : 2;
                    n_acc  = a;
                    n_sub  = s;
                    n_ov   = '{o, o};
                end
            end
        end else begin
            ebz = 1;
            eph = m_held ? ((m_len == 3) ? 2'd2 : 2'd1) : 2'(m_step);
            eaa = (eph == 2'd2) && m_acc;
            eas = (eph == 2'd2) && m_sub;
            if (kl || !e) begin
                n_act = 0;
            end else if (m_held) begin
                evl = 1;
                eov = m_ov;
                if (r) n_act = 0;
            end else if (m_step < m_len - 1) begin
                ewe = 1;
                n_step = m_step + 1;
                for (int k = 0; k < 2; k++) n_ov[k] = merge(k, m_ov[k], o);
            end else begin
                evl = 1;
                for (int k = 0; k < 2; k++) eov[k] = merge(k, m_ov[k], o);
                if (r) n_act = 0;
                else begin
                    n_held = 1;
                    n_ov   = eov;
                end
            end
        end
        for (int k = 0; k < 2; k++)
            check($sformatf("%s[%0d]", tag, k), dut_out(k),
                  {eph, ewe, eaa, eas, evl, ebz, eov[k]});
        @(posedge clk);
        #1;
        m_act = n_act; m_held = n_held; m_step = n_step; m_len = n_len;
        m_acc = n_acc; m_sub = n_sub; m_ov = n_ov;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 0; kill = 0; cc = 2'b00; acc = 0; sub = 0; rdy = 0; ov = 0;
        model_clear();
        @(posedge clk);
        #1;
        check("reset[0]", dut_out(0), 8'h00);
        check("reset[1]", dut_out(1), 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc("idle", 0, 0, 2'b11, 1, 1, 1, 1);
        cyc("one", 1, 0, 2'b00, 0, 0, 1, 1);
        cyc("two_c0", 1, 0, 2'b01, 0, 0, 1, 1);
        cyc("two_c1", 1, 0, 2'b01, 0, 0, 1, 0);
        cyc("gap", 0, 0, 2'b00, 0, 0, 1, 0);
        cyc("msub_c0", 1, 0, 2'b11, 1, 1, 1, 0);
        cyc("msub_c1", 1, 0, 2'b00, 0, 0, 1, 0);
        cyc("msub_c2", 1, 0, 2'b00, 0, 0, 1, 0);
        cyc("stall_c0", 1, 0, 2'b10, 0, 0, 0, 1);
        cyc("stall_c1", 1, 0, 2'b10, 0, 0, 0, 0);
        cyc("stall_h1", 1, 0, 2'b00, 0, 0, 0, 0);
        cyc("stall_h2", 1, 0, 2'b00, 0, 0, 0, 0);
        cyc("stall_ret", 1, 0, 2'b00, 0, 0, 1, 0);
        cyc("idle2", 0, 0, 2'b00, 0, 0, 1, 0);
        cyc("kill_c0", 1, 0, 2'b11, 1, 0, 1, 1);
        cyc("kill_c1", 1, 1, 2'b11, 1, 0, 1, 1);
        cyc("after_kill", 1, 0, 2'b00, 0, 0, 1, 0);
        cyc("idle_kill", 1, 1, 2'b00, 0, 0, 1, 1);
        cyc("acc_stall0", 1, 0, 2'b11, 1, 0, 0, 1);
        cyc("acc_stall1", 1, 0, 2'b11, 1, 0, 0, 0);
        cyc("acc_stall2", 1, 0, 2'b11, 1, 0, 0, 0);
        cyc("acc_hold", 1, 0, 2'b11, 1, 0, 1, 0);

        cyc("rst_c0", 1, 0, 2'b11, 1, 0, 0, 1);
        cyc("rst_c1", 1, 0, 2'b11, 1, 0, 0, 1);
        en = 0;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_async[0]", dut_out(0), 8'h00);
        check("rst_async[1]", dut_out(1), 8'h00);
        @(posedge clk);
        #1;
        check("rst_edge[0]", dut_out(0), 8'h00);
        check("rst_edge[1]", dut_out(1), 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            cyc("rand", $urandom_range(0, 11) != 0,
                $urandom_range(0, 24) == 0, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
